// File: rtl/clyde_rcon_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clyde_rcon_seq_pkg : shared constants and FSM encoding for Clyde    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package clyde_rcon_seq_pkg;

    localparam logic [3:0] CLYDE_W_INIT  = 4'b0001;
    // Final constant of the default-length sequence; must track CLYDE_NROUNDS.
    localparam logic [3:0] CLYDE_W_LAST  = 4'b1110;
    localparam int         CLYDE_NROUNDS = 12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } clyde_state_e;

endpackage
`default_nettype wire

// File: rtl/clyde_rcon_seq_wupd.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Wupd / wupd_inv : forward and inverse 4-bit round-constant LFSR     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module Wupd (
    input  logic [3:0] w,
    output logic [3:0] w_next
);
    assign w_next = {w[2:0], 1'b0} ^ (w[3] ? 4'b0011 : 4'b0000);
endmodule

module wupd_inv (
    input  logic [3:0] w,
    output logic [3:0] w_prev
);
    // Undoes the shift: the bit fed back into w[0]/w[1] was the old w[3].
    assign w_prev = {w[0], w[3], w[2], w[1] ^ w[0]};
endmodule
`default_nettype wire

// File: rtl/clyde_rcon_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clyde_rcon_seq : forward/inverse round-constant sequencer for Clyde |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module clyde_rcon_seq
    import clyde_rcon_seq_pkg::*;
#(
    parameter int NROUNDS = CLYDE_NROUNDS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       decrypt,
    input  logic       step,
    input  logic       abort,
    output logic [3:0] W,
    output logic [3:0] round,
    output logic       busy,
    output logic       last,
    output logic       done
);

    localparam logic [3:0] ROUND_LAST = 4'(NROUNDS - 1);

    clyde_state_e state, state_nxt;
    logic         dir, dir_nxt;
    logic [3:0]   w_nxt, round_nxt;
    logic         done_nxt;
    logic [3:0]   w_fwd, w_inv;

    Wupd u_wupd (
        .w      (W),
        .w_next (w_fwd)
    );

    wupd_inv u_wupd_inv (
        .w      (W),
        .w_prev (w_inv)
    );

    assign busy = (state == ST_RUN);
    assign last = busy && (dir ? (round == 4'd0) : (round == ROUND_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dir   <= 1'b0;
            W     <= 4'b0000;
            round <= 4'd0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
            W     <= w_nxt;
            round <= round_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        w_nxt     = W;
        round_nxt = round;
        done_nxt  = 1'b0;

        if (abort) begin
            state_nxt = ST_IDLE;
            w_nxt     = 4'b0000;
            round_nxt = 4'd0;
        end else if (start) begin
            state_nxt = ST_RUN;
            dir_nxt   = decrypt;
            w_nxt     = decrypt ? CLYDE_W_LAST : CLYDE_W_INIT;
            round_nxt = decrypt ? ROUND_LAST : 4'd0;
        end else if (state == ST_RUN && step) begin
            if (last) begin
                state_nxt = ST_IDLE;
                w_nxt     = 4'b0000;
                round_nxt = 4'd0;
                done_nxt  = 1'b1;
            end else begin
                w_nxt     = dir ? w_inv : w_fwd;
                round_nxt = dir ? round - 4'd1 : round + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clyde_rcon_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_clyde_rcon_seq : directed + random bench with a round-index model|
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_clyde_rcon_seq;

    localparam int NR = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, decrypt = 1'b0, step = 1'b0, abort = 1'b0;
    logic [3:0] W, round;
    logic       busy, last, done;

    int tests = 0;
    int fails = 0;

    // Model: which constant of the published table is current, and in which direction.
    logic [3:0] tab [NR];
    bit         m_active = 1'b0;
    bit         m_dir    = 1'b0;
    int         m_idx    = 0;
    bit         m_done   = 1'b0;

    clyde_rcon_seq #(.NROUNDS(NR)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .decrypt (decrypt),
        .step    (step),
        .abort   (abort),
        .W       (W),
        .round   (round),
        .busy    (busy),
        .last    (last),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic bit m_last();
        return m_active && (m_dir ? (m_idx == 0) : (m_idx == NR - 1));
    endfunction

    task automatic model_edge();
        bit was_last;
        was_last = m_last();
        m_done   = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            m_idx    = 0;
        end else if (abort) begin
            m_active = 1'b0;
            m_idx    = 0;
        end else if (start) begin
            m_active = 1'b1;
            m_dir    = decrypt;
            m_idx    = decrypt ? NR - 1 : 0;
        end else if (m_active && step) begin
            if (was_last) begin
                m_active = 1'b0;
                m_idx    = 0;
                m_done   = 1'b1;
            end else begin
                m_idx = m_dir ? m_idx - 1 : m_idx + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".W"},     W,            m_active ? tab[m_idx] : 4'b0000);
        chk({ctx, ".round"}, round,        m_active ? 4'(m_idx) : 4'd0);
        chk({ctx, ".busy"},  {3'b0, busy}, {3'b0, m_active});
        chk({ctx, ".last"},  {3'b0, last}, {3'b0, m_last()});
        chk({ctx, ".done"},  {3'b0, done}, {3'b0, m_done});
    endtask

    task automatic drive(input string ctx, input bit s, input bit d, input bit st, input bit ab);
        start = s; decrypt = d; step = st; abort = ab;
        model_edge();
        @(posedge clk); #1;
        check_all(ctx);
        start = 1'b0; decrypt = 1'b0; step = 1'b0; abort = 1'b0;
    endtask

    initial begin
        tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110,
                4'b1100, 4'b1011, 4'b0101, 4'b1010, 4'b0111, 4'b1110};

        // Reset held for three cycles, then released with no start.
        #1;
        check_all("rst0");
        repeat (3) drive("rst", 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        repeat (2) drive("idle", 0, 0, 0, 0);

        // Encrypt: start then 12 back-to-back steps, plus one idle cycle for done to fall.
        drive("enc_start", 1, 0, 0, 0);
        chk("enc_first_W", W, 4'b0001);
        for (int i = 0; i < NR; i++) drive("enc_step", 0, 0, 1, 0);
        chk("enc_done", {3'b0, done}, 4'd1);
        drive("enc_post", 0, 0, 0, 0);

        // Decrypt sequence.
        drive("dec_start", 1, 1, 0, 0);
        chk("dec_first_W", W, 4'b1110);
        for (int i = 0; i < NR; i++) drive("dec_step", 0, 0, 1, 0);
        drive("dec_post", 0, 0, 0, 0);

        // Gapped encrypt: step every third cycle.
        drive("gap_start", 1, 0, 0, 0);
        for (int i = 0; i < NR; i++) begin
            drive("gap_hold", 0, 0, 0, 0);
            drive("gap_hold", 0, 0, 0, 0);
            drive("gap_step", 0, 0, 1, 0);
        end
        drive("gap_post", 0, 0, 0, 0);

        // start+step at round 5 restarts; abort+start lands in IDLE; step in IDLE ignored.
        drive("ss_start", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive("ss_step", 0, 0, 1, 0);
        chk("ss_round5", round, 4'd5);
        drive("ss_restart", 1, 0, 1, 0);
        chk("ss_reload_W", W, 4'b0001);
        drive("as_both", 1, 1, 0, 1);
        drive("idle_step", 0, 0, 1, 0);
        drive("idle_step", 0, 0, 1, 0);

        // Abort at round 7.
        drive("ab_start", 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) drive("ab_step", 0, 0, 1, 0);
        drive("ab_abort", 0, 0, 0, 1);
        drive("ab_post", 0, 0, 0, 0);

        // Asynchronous reset at round 3, then a fresh decrypt start.
        drive("rr_start", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive("rr_step", 0, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        m_active = 1'b0; m_idx = 0; m_done = 1'b0;
        check_all("rr_async");
        drive("rr_low", 0, 0, 1, 0);
        #2 rst_n = 1'b1;
        drive("rr_dec", 1, 1, 0, 0);
        chk("rr_dec_W", W, 4'b1110);
        for (int i = 0; i < 4; i++) drive("rr_dec_step", 0, 0, 1, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive("rnd",
                  ($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 40) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clyde_rcon_seq.md
# clyde_rcon_seq

Sequential round-constant sequencer for the masked Clyde-128 core. It produces the 4-bit LFSR constant W for each of the NROUNDS rounds. In encryption mode it steps forward from W = 0001. In decryption mode it starts at the final constant and steps backward through the inverse LFSR. It sits beside the round controller, which requests one new constant per round through a step strobe. Because W is public, the block is unmasked.

## Interface
Parameters:
- NROUNDS, 12, number of Clyde rounds (and constants) per primitive call; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new sequence.
- decrypt  input  1  direction, sampled only when start=1 (0 = forward, 1 = inverse).
- step  input  1  round controller consumed the current W; advance.
- abort  input  1  cancels any sequence; return to IDLE.
- W  output  4  current round constant (registered).
- round  output  4  logical round index of W (encrypt counts up 0..NROUNDS-1; decrypt counts down NROUNDS-1..0).
- busy  output  1  high in RUN.
- last  output  1  high in RUN while W is the final constant of the sequence.
- done  output  1  one-cycle pulse after the last constant is consumed.

## Operation
- Forward update: W' = {W[2:0],0} ^ (W[3] ? 0011 : 0000).
- Inverse update from n = W: W_prev = {n[0], n[3], n[2], n[1]^n[0]}.
- The forward sequence from 0001 is 0001, 0010, 0100, 1000, 0011, 0110, 1100, 1011, 0101, 1010, 0111, 1110. For NROUNDS=12, the last constant is 1110.
- FSM states: IDLE, RUN.
- IDLE: W=0000, round=0, busy=0, last=0. step is ignored.
- On start (in any state), go to RUN.
  - Encrypt: load W=W_INIT (0001), round=0.
  - Decrypt: load W=W_LAST (for NROUNDS=12: 1110), round=NROUNDS-1.
  - Restarting while in RUN discards the current sequence without a done pulse.
- RUN, step with last=0: W takes its forward or inverse update; round increments (encrypt) or decrements (decrypt).
- RUN, step with last=1: go to IDLE, assert done for exactly one cycle, clear W and round.
- last = (decrypt ? round==0 : round==NROUNDS-1) while in RUN; otherwise 0. The direction is latched at start.
- abort: go to IDLE next edge, no done pulse.
- Priority for events in the same cycle: abort > start > step.
- Reset mid-sequence: all outputs take their reset values immediately, state goes to IDLE, no done pulse.

## Timing
- Reset values: W=0000, round=0, busy=0, last=0, done=0.
- start at edge k: W, round, busy and last are valid from edge k+1. At most one step is consumed per cycle.
- step at edge k: the new W and round are visible after edge k. Back-to-back steps on consecutive cycles are legal. A full sequence takes NROUNDS step cycles.
- done rises at the edge after the final step and falls one cycle later. busy is already 0 while done=1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared clyde package holds:
  - CLYDE_W_INIT = 4'b0001;
  - CLYDE_W_LAST = 4'b1110 (valid for the default NROUNDS only; changing NROUNDS requires a matching package constant);
  - CLYDE_NROUNDS = 12;
  - the FSM state encoding.
- The forward update reuses the existing combinational forward-update block, Wupd.
- The inverse update is a new combinational sub-module, wupd_inv (4-bit in, 4-bit out).
- Main module contains the FSM, the round counter, the latched direction and the W register.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, release with no start. Required: W=0000, busy=0, last=0, done=0 throughout.
- Encrypt sequence: start with decrypt=0, then 12 consecutive steps.
  - W after start, before any step: 0001.
  - W after each step: 0010, 0100, 1000, 0011, 0110, 1100, 1011, 0101, 1010, 0111, 1110.
  - last=1 only at round 11 (W=1110); the 12th step yields a single done pulse.
- Decrypt sequence: start with decrypt=1, then 12 steps.
  - W after start, before any step: 1110.
  - W after each step: 0111, 1010, 0101, 1011, 1100, 0110, 0011, 1000, 0100, 0010, 0001.
  - round counts 11 down to 0; last at W=0001; done after the 12th step.
- Gapped steps: encrypt with step asserted every third cycle. Required: W holds between steps, and the sequence matches the encrypt scenario.
- Simultaneous events:
  - start+step in RUN at round 5: reloads 0001, round=0.
  - abort+start: IDLE, no done.
  - step in IDLE: no change.
- Abort and reset mid-run:
  - abort at round 7: W=0000, busy=0 next cycle, no done.
  - rst_n low at round 3: outputs reset at once; after release, a new decrypt start loads 1110 correctly.
